// File: rtl/btn_pkg.sv
// Shared types, defaults and sizing helper for the push-button conditioning front end.
package btn_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_MAX     = 50000;
  localparam int DEF_HOLD_CYC    = 50000000;
  localparam int DEF_REPEAT_CYC  = 10000000;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } btn_evt_t;

  typedef enum logic {
    RPT_HOLD,
    RPT_REPEAT
  } rpt_state_t;

  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bus between the raw board inputs and the conditioned level/pulse outputs.
interface button_conditioner_if #(
  parameter int N_BTN = 3
);
  logic [N_BTN-1:0] btn_i;
  logic [N_BTN-1:0] level_o;
  logic [N_BTN-1:0] rise_o;
  logic [N_BTN-1:0] fall_o;

  modport master (output btn_i, input level_o, input rise_o, input fall_o);
  modport slave  (input btn_i, output level_o, output rise_o, output fall_o);
endinterface

// File: rtl/debounce_channel.sv
// One button channel: synchronizer, counter debounce filter, registered rise/fall pulses.
// Optional hold-to-repeat on rise is built only when AUTOREPEAT_EN is defined.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_MAX     = DEF_CNT_MAX,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int REPEAT_CYC  = DEF_REPEAT_CYC
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     btn,
  output btn_evt_t evt
);

  localparam int CW = cnt_w(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_channel: SYNC_STAGES must be at least 2");
  end
  if (CNT_MAX < 1 || HOLD_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_cnt
    $error("debounce_channel: CNT_MAX, HOLD_CYC and REPEAT_CYC must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   synced;
  logic                   differ;
  logic                   toggle;
  logic                   rpt_fire;

  assign synced = sync_q[SYNC_STAGES-1];
  assign differ = synced != level_q;
  // The counter only ever reaches CNT_LAST, because reaching it while still differing clears it.
  assign toggle = differ && (cnt_q == CNT_LAST);

`ifdef AUTOREPEAT_EN
  localparam int HW = cnt_w((HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_CYC - 1);

  rpt_state_t    rpt_state_q, rpt_state_d;
  logic [HW-1:0] hold_q, hold_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    rpt_state_d = rpt_state_q;
    hold_d      = hold_q;
    rpt_fire    = 1'b0;
    if (!level_q || toggle) begin
      rpt_state_d = RPT_HOLD;
      hold_d      = '0;
    end else begin
      unique case (rpt_state_q)
        RPT_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            rpt_fire    = 1'b1;
            hold_d      = '0;
            rpt_state_d = RPT_REPEAT;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        RPT_REPEAT: begin
          if (hold_q == REPEAT_LAST) begin
            rpt_fire = 1'b1;
            hold_d   = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: begin
          rpt_state_d = RPT_HOLD;
          hold_d      = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_state_q <= RPT_HOLD;
      hold_q      <= '0;
    end else begin
      rpt_state_q <= rpt_state_d;
      hold_q      <= hold_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a true shift chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      if (!differ || toggle) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (toggle) begin
        level_q <= ~level_q;
      end
      rise_q <= (toggle && !level_q) || rpt_fire;
      fall_q <= toggle && level_q;
    end
  end

  assign evt = '{level: level_q, rise: rise_q, fall: fall_q};

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw push-buttons into debounced levels and single-cycle rise/fall pulses.
// Define AUTOREPEAT_EN to add hold-to-repeat rise pulses.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN       = 3,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_MAX     = DEF_CNT_MAX,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int REPEAT_CYC  = DEF_REPEAT_CYC
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave bus
);

  btn_evt_t         evt [N_BTN];
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_MAX     (CNT_MAX),
      .HOLD_CYC    (HOLD_CYC),
      .REPEAT_CYC  (REPEAT_CYC)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .btn   (bus.btn_i[i]),
      .evt   (evt[i])
    );

    assign level[i] = evt[i].level;
    assign rise[i]  = evt[i].rise;
    assign fall[i]  = evt[i].fall;
  end

  assign bus.level_o = level;
  assign bus.rise_o  = rise;
  assign bus.fall_o  = fall;

endmodule
